issue_unit: RTL

- Sits directly downstream of the dispatcher's four reservation stations (int, ld/st, mult, div).
- Each cycle it decides which ready stations may issue. It returns the issue_done pops that release the issued entries, and it schedules each result's future CDB slot so that no two execution units drive the CDB in the same cycle.
- It also sequences the non-pipelined divider and drives CDB mux ownership each cycle.

---
 rtl/issue_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/issue_unit.sv
// Issue unit: grants ready reservation stations and books future CDB slots
// so that no two execution units broadcast in the same cycle.
module issue_unit #(
    parameter int INT_LAT   = 1,
    parameter int MEM_LAT   = 2,
    parameter int MULT_LAT  = 4,
    parameter int DIV_LAT   = 7,
    parameter int SRB_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       int_issue_rdy,
    input  logic       mem_issue_rdy,
    input  logic       mult_issue_rdy,
    input  logic       div_issue_rdy,
    output logic       issue_done_int,
    output logic       issue_done_mem,
    output logic       issue_done_mult,
    output logic       issue_done_div,
    output logic       cdb_owner_valid,
    output logic [1:0] cdb_owner,
    output logic       div_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    localparam logic [1:0] OWN_INT  = 2'b00;
    localparam logic [1:0] OWN_MEM  = 2'b01;
    localparam logic [1:0] OWN_MULT = 2'b10;
    localparam logic [1:0] OWN_DIV  = 2'b11;

    // Equal-latency pairs compete for the same CDB slot in one cycle.
    localparam logic SAME_IM  = (INT_LAT == MEM_LAT);
    localparam logic SAME_ID  = (INT_LAT == DIV_LAT);
    localparam logic SAME_IX  = (INT_LAT == MULT_LAT);
    localparam logic SAME_MD  = (MEM_LAT == DIV_LAT);
    localparam logic SAME_MX  = (MEM_LAT == MULT_LAT);
    localparam logic SAME_XD  = (MULT_LAT == DIV_LAT);

    logic [SRB_DEPTH-1:0]      srb_v;
    logic [SRB_DEPTH-1:0][1:0] srb_own;
    logic [CW-1:0]             div_cnt;
    logic                      rr_ptr;
    logic                      run;

    logic int_el;
    logic mem_el;
    logic mult_el;
    logic div_el;
    logic g_int;
    logic g_mem;
    logic g_mult;
    logic g_div;
    logic int_free;
    logic mem_free;
    logic rr_tog;

    // The divider may be regranted in the cycle its counter reaches 1,
    // because the counter is reloaded at the same edge it would hit 0.
    assign int_el  = run & int_issue_rdy  & ~srb_v[INT_LAT];
    assign mem_el  = run & mem_issue_rdy  & ~srb_v[MEM_LAT];
    assign mult_el = run & mult_issue_rdy & ~srb_v[MULT_LAT];
    assign div_el  = run & div_issue_rdy  & ~srb_v[DIV_LAT]
                   & (div_cnt <= CW'(1));

    // Priority arbitration among units that target the same CDB slot.
    always_comb begin
        g_div    = div_el;
        g_mult   = mult_el & ~(SAME_XD & g_div);
        int_free = ~((SAME_ID & g_div) | (SAME_IX & g_mult));
        mem_free = ~((SAME_MD & g_div) | (SAME_MX & g_mult));
        g_int    = int_el & int_free
                 & ~(SAME_IM & rr_ptr & mem_el & mem_free);
        g_mem    = mem_el & mem_free
                 & ~(SAME_IM & ~rr_ptr & int_el & int_free);
        rr_tog   = SAME_IM & int_el & int_free & mem_el & mem_free;
    end

    assign issue_done_int  = g_int;
    assign issue_done_mem  = g_mem;
    assign issue_done_mult = g_mult;
    assign issue_done_div  = g_div;

    assign cdb_owner_valid = srb_v[0];
    assign cdb_owner       = srb_own[0];
    assign div_busy        = (div_cnt != '0);

    // Shift the slot reservations down one cycle and book new grants.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            srb_v   <= '0;
            srb_own <= '0;
        end else begin
            srb_v   <= {1'b0, srb_v[SRB_DEPTH-1:1]};
            srb_own <= {2'b00, srb_own[SRB_DEPTH-1:1]};
            if (g_int) begin
                srb_v[INT_LAT-1]   <= 1'b1;
                srb_own[INT_LAT-1] <= OWN_INT;
            end
            if (g_mem) begin
                srb_v[MEM_LAT-1]   <= 1'b1;
                srb_own[MEM_LAT-1] <= OWN_MEM;
            end
            if (g_mult) begin
                srb_v[MULT_LAT-1]   <= 1'b1;
                srb_own[MULT_LAT-1] <= OWN_MULT;
            end
            if (g_div) begin
                srb_v[DIV_LAT-1]   <= 1'b1;
                srb_own[DIV_LAT-1] <= OWN_DIV;
            end
        end
    end

    // Divider occupancy counter, round-robin pointer and start-up gate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            rr_ptr  <= 1'b0;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (g_div) begin
                div_cnt <= CW'(DIV_LAT - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - CW'(1);
            end
            if (rr_tog) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

endmodule
